mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port DRAM/peripheral bus between the instruction-fetch stage and the MEM stage of the RV32 pipeline.
- Latches one request at a time and drives the bus with a req/ready handshake.
- Returns read data or write completion to the owning requester and raises per-requester stall signals for the hazard logic.
- Data has priority over fetch; a bounded starvation counter guarantees fetch progress, and a response watchdog prevents bus hangs.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced; 0 = strict data priority.
- TIMEOUT, 64, max cycles in WAIT before forced error completion; 0 = watchdog disabled.
- TO_W, 8, width of the watchdog counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction, valid with if_valid
- if_valid  out  1  fetch completion pulse
- if_stall  out  1  if_req & ~if_valid
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_mask  in  2  access size: 00 byte, 01 half, 10 word
- d_rdata  out  32  load data, valid with d_valid
- d_valid  out  1  data completion pulse (load or store)
- d_stall  out  1  d_req & ~d_valid
- d_err  out  1  load completed by watchdog; coincident with d_valid
- bus_req  out  1  transaction request to bus
- bus_we  out  1  write enable
- bus_addr  out  32  latched address
- bus_wdata  out  32  latched store data
- bus_mask  out  2  latched mask; 10 for fetches
- bus_ready  in  1  bus accepts the request this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:
- Reset:
  - State is IDLE; starvation and watchdog counters are 0; owner is none.
  - bus_req, if_valid, d_valid and d_err are 0; bus_addr, bus_wdata, bus_we and bus_mask are 0.
  - rst mid-transaction aborts it with no completion pulse.
  - bus_rvalid arriving after reset is ignored.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - If d_req and if_req are both high and the starvation counter equals STARVE_LIMIT, grant fetch.
  - Otherwise, if d_req is high, grant data; else if if_req is high, grant fetch.
  - On grant, latch owner, address, wdata, we and mask (fetch forces we = 0, mask = 10), then go to ISSUE.
  - With no request, stay in IDLE.
  - bus_rvalid is ignored in IDLE.
- ISSUE:
  - bus_req is high with the latched fields.
  - When bus_ready is high and the transaction is a write: d_valid = 1 in this cycle, then go to IDLE.
  - When bus_ready is high and the transaction is a read: go to WAIT and clear the watchdog.
  - While bus_ready is low, hold all bus outputs stable.
  - bus_rvalid is ignored in ISSUE.
- WAIT:
  - bus_req is 0.
  - When bus_rvalid is high, the owner's valid = 1 and rdata = bus_rdata in the same cycle, then go to IDLE.
  - Otherwise the watchdog increments.
  - When the watchdog reaches TIMEOUT (TIMEOUT ≠ 0): complete with rdata = 0, assert d_err if the owner is data (fetch gets no error flag), go to IDLE.
  - The bus must not return rvalid after a timeout.
- Latency and throughput:
  - Minimum load/fetch latency is 3 cycles from request to valid: request seen in IDLE, ISSUE with ready, rvalid in the first WAIT cycle.
  - Minimum store latency is 2 cycles.
  - Every transaction returns through IDLE, so at most one transaction is outstanding.
- Starvation counter (updated at grant time in IDLE):
  - Increment, saturating at STARVE_LIMIT, when data is granted while if_req is high.
  - Clear when fetch is granted, or when data is granted with if_req low.
- Response routing:
  - if_rdata and d_rdata equal bus_rdata whenever the respective valid is high; otherwise they are 0.
  - Valids are never asserted for a non-owner.
- Requester behaviour:
  - A requester that deasserts its request before completion still receives its valid pulse; the transaction is not cancelled.
  - The same requester may re-request in the cycle after its valid.
- Both requests rising in the same cycle is resolved only by the IDLE priority rule; no combinational path exists from a request to bus_req.

Test Plan:
- Reset then single fetch: if_addr = 0x8000_0000, bus_ready = 1, rvalid 1 cycle later with 0x0000_0013 → if_valid on cycle 3 with if_rdata = 0x13; if_stall high on cycles 1–2.
- Simultaneous requests with STARVE_LIMIT = 4: continuous d_req loads plus if_req → 4 data completions, then a fetch grant, counter = 0, then data resumes.
- Store to 0x1000_0000 with d_wdata = 0xCAFE_BABE, d_mask = 00, bus_ready held low 3 cycles → bus fields stable for all 4 ISSUE cycles; d_valid in the ready cycle; no WAIT state entered.
- Load with no rvalid, TIMEOUT = 64 → d_valid and d_err exactly 64 WAIT cycles after acceptance, d_rdata = 0; a following fetch completes normally.
- rst asserted in WAIT, with rvalid arriving the next cycle → no valid pulse, bus_req = 0, state IDLE, counters 0.
- Requester drops d_req in ISSUE → transaction still completes with d_valid; a new fetch is granted afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port bus arbiter between instruction fetch and data access
// Data wins by default; a saturating starvation count forces fetch, and a watchdog bounds WAIT.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64,
  parameter int TO_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_mask,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        d_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_mask,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  state_t          state, state_nx;
  owner_t          owner;
  logic [SW-1:0]   starve;
  logic [TO_W-1:0] wdog;
  logic            grant_if, grant_d, done, timed_out;

  always_comb begin
    state_nx  = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        // STARVE_LIMIT of 0 means fetch is never forced ahead of data.
        if (d_req && if_req && (STARVE_LIMIT != 0) && (starve == STARVE_MAX))
          grant_if = 1'b1;
        else if (d_req)
          grant_d = 1'b1;
        else if (if_req)
          grant_if = 1'b1;
        if (grant_if || grant_d)
          state_nx = ISSUE;
      end
      ISSUE: begin
        if (bus_ready) begin
          if (bus_we) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if ((TIMEOUT != 0) && (wdog == TO_LAST)) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Completions are gated by rst so an aborted transaction never pulses.
  assign if_valid = done && (owner == OWN_IF) && !rst;
  assign d_valid  = done && (owner == OWN_D) && !rst;
  assign d_err    = d_valid && timed_out;
  assign if_rdata = (if_valid && !timed_out) ? bus_rdata : 32'h0;
  assign d_rdata  = (d_valid && !timed_out) ? bus_rdata : 32'h0;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;
  assign bus_req  = (state == ISSUE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      starve    <= '0;
      wdog      <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_mask  <= 2'b00;
    end else begin
      state <= state_nx;
      if (grant_d) begin
        owner     <= OWN_D;
        bus_we    <= d_we;
        bus_addr  <= d_addr;
        bus_wdata <= d_wdata;
        bus_mask  <= d_mask;
        starve    <= if_req ? ((starve == STARVE_MAX) ? starve : starve + 1'b1) : '0;
      end else if (grant_if) begin
        owner     <= OWN_IF;
        bus_we    <= 1'b0;
        bus_addr  <= if_addr;
        bus_wdata <= 32'h0;
        bus_mask  <= 2'b10;
        starve    <= '0;
      end else if (done) begin
        owner <= OWN_NONE;
      end
      if (state == ISSUE && bus_ready)
        wdog <= '0;
      else if (state == WAIT)
        wdog <= wdog + 1'b1;
    end
  end

endmodule
